// File: rtl/pwm_cfg_pkg.sv
// rtl/pwm_cfg_pkg.sv - shared types and constants for the PWM configuration sequencer
package pwm_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FINISH
  } state_t;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [7:0] REG_OFF_0 = 8'h0;
  localparam logic [7:0] REG_OFF_1 = 8'h4;
  localparam logic [7:0] REG_OFF_2 = 8'h8;
  localparam logic [7:0] REG_OFF_3 = 8'hC;

  function automatic logic [7:0] reg_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    return REG_OFF_0;
      2'd1:    return REG_OFF_1;
      2'd2:    return REG_OFF_2;
      default: return REG_OFF_3;
    endcase
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer.sv
// rtl/pwm_cfg_sequencer.sv - AXI4-Lite master that writes four PWM registers and optionally reads them back
module pwm_cfg_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            verify_en,
  input  logic [127:0]                    cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  import pwm_cfg_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

  state_t       state, state_nxt;
  logic [1:0]   k, k_nxt;
  logic [127:0] cfg, cfg_nxt;
  logic         verify, verify_nxt;
  logic         err_q, err_nxt;
  logic         aw_done, aw_done_nxt;
  logic         w_done, w_done_nxt;
  logic         aw_hs, w_hs;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_k;
  logic [C_M_AXI_DATA_WIDTH-1:0] word_k;

  assign addr_k = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(reg_offset(k));
  assign word_k = cfg[{k, 5'b0} +: 32];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= IDLE;
      k       <= '0;
      cfg     <= '0;
      verify  <= 1'b0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      cfg     <= cfg_nxt;
      verify  <= verify_nxt;
      err_q   <= err_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // VALIDs depend only on registered state/flags; READYs only steer the next state.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    cfg_nxt       = cfg;
    verify_nxt    = verify;
    err_nxt       = err_q;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    done          = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          cfg_nxt     = cfg_data;
          verify_nxt  = verify_en;
          err_nxt     = 1'b0;
          k_nxt       = '0;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = WR_ADDR_DATA;
        end
      end
      WR_ADDR_DATA: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_AWADDR  = addr_k;
        M_AXI_WVALID  = !w_done;
        M_AXI_WDATA   = word_k;
        M_AXI_WSTRB   = '1;
        aw_hs = !aw_done && M_AXI_AWREADY;
        w_hs  = !w_done && M_AXI_WREADY;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = WR_RESP;
        end else begin
          aw_done_nxt = aw_done || aw_hs;
          w_done_nxt  = w_done || w_hs;
        end
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_nxt   = 1'b1;
            state_nxt = FINISH;
          end else if (k != LAST_IDX) begin
            k_nxt     = k + 2'd1;
            state_nxt = WR_ADDR_DATA;
          end else if (verify) begin
            k_nxt     = '0;
            state_nxt = RD_ADDR;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = addr_k;
        if (M_AXI_ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != word_k) begin
            err_nxt   = 1'b1;
            state_nxt = FINISH;
          end else if (k != LAST_IDX) begin
            k_nxt     = k + 2'd1;
            state_nxt = RD_ADDR;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign err          = err_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb/tb_pwm_cfg_sequencer.sv - scoreboard bench for pwm_cfg_sequencer with a behavioural AXI4-Lite slave
module tb_pwm_cfg_sequencer;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         start = 1'b0;
  logic         verify_en = 1'b0;
  logic [127:0] cfg_data = '0;
  logic         busy, done, err;
  logic [3:0]   M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic         M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic         M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [31:0]  M_AXI_WDATA;
  logic [3:0]   M_AXI_WSTRB;
  logic [1:0]   M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0]  M_AXI_RDATA = '0;

  pwm_cfg_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .verify_en(verify_en), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic err;
    int   lat;
  } done_t;

  done_t       exp_done[$];
  logic [3:0]  exp_aw[$];
  logic [3:0]  exp_ar[$];
  logic [31:0] exp_w[$];

  logic [31:0] mem[4];
  logic [3:0]  cap_addr, ar_q, aw_pend_addr;
  logic [31:0] cap_data;
  bit          cap_a, cap_d, aw_pend, w_pend, ar_pend;
  int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  int err_wr_idx = -1, bad_rd_idx = -1, b_cnt = 0, r_cnt = 0;
  int cyc = 0, start_cyc = 0;
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected beat expected none", name);
  endtask

  // Slave: decisions for the coming cycle are made just after each rising edge.
  initial forever begin
    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
    end else begin
      M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
      M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_dly);
      M_AXI_BVALID  = M_AXI_BREADY;
      M_AXI_BRESP   = (b_cnt == err_wr_idx) ? 2'b10 : 2'b00;
      M_AXI_ARREADY = M_AXI_ARVALID;
      M_AXI_RVALID  = M_AXI_RREADY;
      M_AXI_RDATA   = (r_cnt == bad_rd_idx) ? 32'hDEADBEEF : mem[ar_q[3:2]];
      M_AXI_RRESP   = 2'b00;
    end
  end

  // Monitor: everything that fires at the next rising edge is visible here.
  initial forever begin
    @(negedge ACLK);
    cyc++;
    if (!ARESETN) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (aw_pend) chk("aw_hold", 64'({M_AXI_AWVALID, M_AXI_AWADDR}), 64'({1'b1, aw_pend_addr}));
      if (w_pend)  chk("w_hold", 64'(M_AXI_WVALID), 64'(1'b1));
      if (ar_pend) chk("ar_hold", 64'(M_AXI_ARVALID), 64'(1'b1));
      aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_pend_addr = M_AXI_AWADDR;
      w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
      ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
      if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;

      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_cnt = 0;
        if (exp_aw.size() == 0) unexpected("aw_beat");
        else chk("aw_addr", 64'(M_AXI_AWADDR), 64'(exp_aw.pop_front()));
        chk("aw_prot", 64'(M_AXI_AWPROT), 64'(0));
        cap_addr = M_AXI_AWADDR; cap_a = 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_cnt = 0;
        if (exp_w.size() == 0) unexpected("w_beat");
        else chk("w_data", 64'(M_AXI_WDATA), 64'(exp_w.pop_front()));
        chk("w_strb", 64'(M_AXI_WSTRB), 64'(4'hF));
        cap_data = M_AXI_WDATA; cap_d = 1;
      end
      if (cap_a && cap_d) begin
        mem[cap_addr[3:2]] = cap_data;
        cap_a = 0; cap_d = 0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (exp_ar.size() == 0) unexpected("ar_beat");
        else chk("ar_addr", 64'(M_AXI_ARADDR), 64'(exp_ar.pop_front()));
        ar_q = M_AXI_ARADDR;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) b_cnt++;
      if (M_AXI_RVALID && M_AXI_RREADY) r_cnt++;
      if (start && !busy) start_cyc = cyc;
      if (done) begin
        if (exp_done.size() == 0) unexpected("done_pulse");
        else begin
          done_t e;
          e = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(e.err));
          if (e.lat != 0) chk("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_outs"}, 64'({busy, done, err, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                               M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    chk({tag, "_addr_data"}, 64'({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}), 64'(0));
  endtask

  task automatic run(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                     input logic [31:0] w3, input logic ver, input int wr_err, input int rd_bad,
                     input logic exp_err, input int lat, input int extra_starts);
    logic [31:0] w[4];
    int nw, nr;
    bit seen;
    done_t d;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    nw = (wr_err >= 0) ? wr_err + 1 : 4;
    nr = (!ver || wr_err >= 0) ? 0 : ((rd_bad >= 0) ? rd_bad + 1 : 4);
    for (int i = 0; i < nw; i++) begin
      exp_aw.push_back(4'(4 * i));
      exp_w.push_back(w[i]);
    end
    for (int i = 0; i < nr; i++) exp_ar.push_back(4'(4 * i));
    d.err = exp_err; d.lat = lat;
    exp_done.push_back(d);
    err_wr_idx = wr_err; bad_rd_idx = rd_bad; b_cnt = 0; r_cnt = 0;

    @(posedge ACLK); #2;
    start = 1'b1; verify_en = ver; cfg_data = {w3, w2, w1, w0};
    @(posedge ACLK); #2;
    start = 1'b0; verify_en = 1'b0; cfg_data = '1;
    @(negedge ACLK);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_cleared", 64'(err), 64'(0));
    for (int i = 0; i < extra_starts; i++) begin
      @(posedge ACLK); #2; start = 1'b1; verify_en = 1'b1;
      @(posedge ACLK); #2; start = 1'b0; verify_en = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge ACLK);
      if (done) seen = 1;
    end
    if (!seen) unexpected("done_timeout");
    repeat (4) @(negedge ACLK);
    chk("idle_after_done", 64'(busy), 64'(0));
    chk("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size()), 64'(0));
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge ACLK);
    #2 ARESETN = 1'b1;

    run(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, -1, -1, 1'b0, 9, 0);
    run(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, -1, -1, 1'b0, 17, 0);

    aw_dly = 3; w_dly = 0;
    run(32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003, 32'hF0F0_0004, 1'b0, -1, -1, 1'b0, 21, 0);
    aw_dly = 0; w_dly = 3;
    run(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b1, -1, -1, 1'b0, 29, 0);
    aw_dly = 2; w_dly = 2;
    run(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 1'b0, -1, -1, 1'b0, 17, 0);
    aw_dly = 0; w_dly = 0;

    run(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 1, -1, 1'b1, 5, 0);
    chk("err_held", 64'(err), 64'(1));
    run(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, -1, -1, 1'b0, 9, 0);

    run(32'd1, 32'd2, 32'd3, 32'd4, 1'b1, -1, 2, 1'b1, 15, 0);

    run(32'h10, 32'h20, 32'h30, 32'h40, 1'b0, -1, -1, 1'b0, 9, 2);

    aw_dly = 20; w_dly = 0;
    exp_aw.push_back(4'h0);
    exp_w.push_back(32'h0000_0077);
    @(posedge ACLK); #2;
    start = 1'b1; cfg_data = {96'h0, 32'h0000_0077};
    @(posedge ACLK); #2;
    start = 1'b0;
    @(posedge ACLK); @(posedge ACLK); #2;
    chk("aw_pending_before_reset", 64'(M_AXI_AWVALID), 64'(1));
    #1 ARESETN = 1'b0;
    #1 check_idle_outputs("async_reset");
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_done.delete();
    aw_cnt = 0; w_cnt = 0; cap_a = 0; cap_d = 0; aw_dly = 0;
    @(posedge ACLK); #2;
    check_idle_outputs("held_reset");
    ARESETN = 1'b1;
    run(32'd5, 32'd6, 32'd7, 32'd8, 1'b1, -1, -1, 1'b0, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, meaning the AXI4-Lite address width.
REQ-002 SHALL have parameter C_BASE_ADDR, default 0, meaning the base address of the PWM register bank.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, meaning the data width; only 32 is supported.
REQ-004 ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to load a configuration.
REQ-007 verify_en  in  1  read-back-and-compare after the writes; sampled with start.
REQ-008 cfg_data  in  128  four register words; word k = bits [32k+31:32k]; sampled with start.
REQ-009 busy  out  1  sequence in progress.
REQ-010 done  out  1  one-cycle pulse at end of sequence.
REQ-011 err  out  1  result of last sequence: 1 = failed; held until next accepted start.
REQ-012 M_AXI_AW*: AWADDR (C_M_AXI_ADDR_WIDTH) out, AWPROT 3 out, AWVALID 1 out, AWREADY 1 in.
REQ-013 M_AXI_W*: WDATA 32 out, WSTRB 4 out, WVALID 1 out, WREADY 1 in.
REQ-014 M_AXI_B*: BRESP 2 in, BVALID 1 in, BREADY 1 out.
REQ-015 M_AXI_AR*/R*: ARADDR out, ARPROT 3 out, ARVALID out, ARREADY in, RDATA 32 in, RRESP 2 in, RVALID in, RREADY out.

Function
REQ-016 States SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and FINISH.
REQ-017 In IDLE, start=1 SHALL latch cfg_data and verify_en, clear err, clear word index k, and go to WR_ADDR_DATA; start outside IDLE SHALL be ignored.
REQ-018 WR_ADDR_DATA SHALL assert AWVALID and WVALID together with AWADDR=C_BASE_ADDR+4k, WDATA=word k, WSTRB=4'hF, AWPROT=0.
REQ-019 In WR_ADDR_DATA, each VALID SHALL drop independently the cycle after its own READY is sampled high; the block SHALL enter WR_RESP once both channels have handshaken, in either order or the same cycle.
REQ-020 WR_RESP SHALL hold BREADY=1 until BVALID.
REQ-021 On a write response with BRESP != OKAY, the block SHALL set err and go to FINISH.
REQ-022 On a write response with BRESP = OKAY, the block SHALL increment k: if k<3, return to WR_ADDR_DATA; if k=3, reset k and go to RD_ADDR when verify_en is latched, otherwise go to FINISH.
REQ-023 RD_ADDR SHALL assert ARVALID with ARADDR=C_BASE_ADDR+4k and ARPROT=0 until ARREADY, then go to RD_DATA.
REQ-024 RD_DATA SHALL hold RREADY=1 until RVALID.
REQ-025 On a read response with RRESP != OKAY or RDATA != word k, the block SHALL set err and go to FINISH.
REQ-026 On a matching read response, the block SHALL increment k: if k<3, go to RD_ADDR; if k=3, go to FINISH.
REQ-027 FINISH SHALL pulse done for exactly one cycle, then return to IDLE; busy=1 in every state except IDLE.
REQ-028 Once asserted, a VALID SHALL NOT drop before its READY handshake; no combinational path SHALL exist from any READY to any VALID.
REQ-029 Minimum latency with zero-wait slaves SHALL be: no verify, start to done = 4×2+1 = 9 cycles; with verify, 17 cycles.
REQ-030 The 2-bit index k SHALL wrap 3→0 only at the write-to-read transition.

Reset
REQ-031 ARESETN=0 SHALL immediately force IDLE, k=0, busy=0, done=0, err=0, all VALID/READY outputs 0, and all address/data outputs 0, including mid-transaction.
REQ-032 After ARESETN deasserts, the first start SHALL be accepted no earlier than the first rising edge after deassertion.

Structure
REQ-033 A shared package pwm_cfg_pkg SHALL hold the state enum, register offsets (0x0, 0x4, 0x8, 0xC), the OKAY response code and NUM_REGS=4.
REQ-034 The design SHALL be a single module with no sub-modules; the independent AW/W handshake tracking is two flag bits inside it.

Verification
REQ-035 Zero-wait slave, cfg_data words 1,2,3,4, verify_en=0 -> writes of 1..4 to 0x0..0xC in order; done exactly 9 cycles after start; err=0.
REQ-036 Same stimulus, verify_en=1, slave returns written data -> four reads at 0x0..0xC; done at cycle 17; err=0.
REQ-037 WREADY 3 cycles before AWREADY, then swapped order, then same cycle -> exactly one AW and one W beat per word; no VALID drops early.
REQ-038 BRESP=SLVERR on the 2nd write -> no 3rd write or any read issued; done pulses; err=1; a new start clears err.
REQ-039 Read-back of word 2 returns 0xDEADBEEF instead of 3 -> err=1; no 4th read; done pulses.
REQ-040 ARESETN low while AWVALID=1, and start pulses while busy -> outputs zero asynchronously; extra starts are ignored, with no second sequence.
